output_fifo_drain: RTL and testbench

//  Consumer side of the convolution output pixel FIFO. Pops W-bit result pixels via the FIFO's
//  rd_en/rd_data/empty port (rd_data registered, valid the cycle after rd_en). Packs OUT_W/W

---
 rtl/output_fifo_drain.sv | 157 +++++++++++++++
 tb/tb_output_fifo_drain.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_fifo_drain.sv
// output_fifo_drain
//   Drains W-bit pixels from the convolution output FIFO, packs PACK = OUT_W/W
//   pixels little-endian into one output word and hands the word to the
//   readout over a valid/ready stream with byte-lane keep and frame-end marking.
//
//   Handshake: a word is transferred on every clock edge where out_valid and
//   out_ready are both 1. While out_valid is 1, out_data, out_keep and out_last
//   hold steady, and out_valid stays 1 until that transfer happens.
//
//   Optional feature macro: DRAIN_STATS_EN (accepted-word and stall counters).
module output_fifo_drain #(
  parameter int W     = 8,
  parameter int OUT_W = 32,
  parameter int CNT_W = 20
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic                 fifo_rd_en,
  input  logic [W-1:0]         fifo_rd_data,
  input  logic                 fifo_empty,
  input  logic                 fifo_wr_mon,
  input  logic [CNT_W-1:0]     frame_len,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic [OUT_W/W-1:0]   out_keep,
  output logic                 out_last,
  output logic [31:0]          stat_words,
  output logic [31:0]          stat_stalls
);

  localparam int PACK = OUT_W / W;
  localparam int LCW  = $clog2(PACK + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state;
  logic [LCW-1:0]   lane_cnt;
  logic [LCW-1:0]   lane_inc;
  logic [CNT_W-1:0] pix_cnt;
  logic [CNT_W-1:0] pix_inc;
  logic [CNT_W-1:0] frame_len_q;
  logic [CNT_W-1:0] eff_len;
  logic             flush_pend;
  logic             pop_ok;
  logic             frame_end;

  // Lane-valid mask with the lowest n lanes set.
  function automatic logic [PACK-1:0] keep_mask(input logic [LCW-1:0] n);
    logic [PACK-1:0] m;
    m = '0;
    for (int i = 0; i < PACK; i++) begin
      if (LCW'(i) < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Pop decision and frame-end detection; a new frame uses the live frame_len.
  always_comb begin
    pop_ok    = (state == S_IDLE) && !fifo_empty && !fifo_wr_mon;
    lane_inc  = lane_cnt + 1'b1;
    pix_inc   = pix_cnt + 1'b1;
    eff_len   = (pix_cnt == '0) ? frame_len : frame_len_q;
    frame_end = (eff_len != '0) && (pix_inc == eff_len);
  end

  // Pop strobe is forced low while in reset so no pop is issued to the shared-reset FIFO.
  assign fifo_rd_en = rstn && pop_ok;

  // Main FSM: pop, capture/pack, present word; all outputs registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      lane_cnt    <= '0;
      pix_cnt     <= '0;
      frame_len_q <= '0;
      flush_pend  <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_keep    <= '0;
      out_last    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop_ok) begin
            state <= S_WAIT;
          end else if (flush_pend && fifo_empty) begin
            flush_pend <= 1'b0;
            if (lane_cnt != '0) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              out_keep  <= keep_mask(lane_cnt);
            end
          end
        end
        S_WAIT: begin
          for (int i = 0; i < PACK; i++) begin
            if (lane_cnt == LCW'(i)) out_data[i*W +: W] <= fifo_rd_data;
          end
          lane_cnt <= lane_inc;
          if (pix_cnt == '0) frame_len_q <= frame_len;
          if (frame_end) begin
            pix_cnt  <= '0;
            out_last <= 1'b1;
          end else begin
            pix_cnt <= pix_inc;
          end
          if ((lane_inc == LCW'(PACK)) || frame_end) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            out_keep  <= keep_mask(lane_inc);
          end else begin
            state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            lane_cnt  <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
      // A flush arriving in any state, including S_OUT, is held for the next word.
      if (flush) flush_pend <= 1'b1;
    end
  end

`ifdef DRAIN_STATS_EN
  // Saturating counters of accepted words and back-pressured output cycles.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stat_words  <= '0;
      stat_stalls <= '0;
    end else if (state == S_OUT) begin
      if (out_ready) begin
        if (stat_words != 32'hFFFF_FFFF) stat_words <= stat_words + 32'd1;
      end else begin
        if (stat_stalls != 32'hFFFF_FFFF) stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`else
  assign stat_words  = '0;
  assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_output_fifo_drain.sv
// tb_output_fifo_drain
//   Bench for output_fifo_drain: a behavioural FIFO feeds the drain, a vector
//   table covers the packing/framing cases and hand-written sequences cover
//   back-pressure, write-monitor blocking and mid-operation reset.
module tb_output_fifo_drain;

  localparam int W     = 8;
  localparam int OUT_W = 32;
  localparam int CNT_W = 20;
  localparam int PACK  = OUT_W / W;
  localparam int EW    = OUT_W + PACK + 1;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              fifo_rd_en;
  logic [W-1:0]      fifo_rd_data = '0;
  logic              fifo_empty   = 1'b1;
  logic              fifo_wr_mon  = 1'b0;
  logic [W-1:0]      wr_data      = '0;
  logic [CNT_W-1:0]  frame_len    = '0;
  logic              flush        = 1'b0;
  logic              out_valid;
  logic              out_ready    = 1'b1;
  logic [OUT_W-1:0]  out_data;
  logic [PACK-1:0]   out_keep;
  logic              out_last;
  logic [31:0]       stat_words;
  logic [31:0]       stat_stalls;

  output_fifo_drain #(.W(W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .fifo_empty   (fifo_empty),
    .fifo_wr_mon  (fifo_wr_mon),
    .frame_len    (frame_len),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .stat_words   (stat_words),
    .stat_stalls  (stat_stalls)
  );

  // ---------------- behavioural FIFO ----------------
  // fifo_wr_mon doubles as the FIFO write strobe; a simultaneous read and write is dropped.
  logic [W-1:0] fifo_q[$];
  always @(posedge clk) begin
    if (!rstn) begin
      fifo_q.delete();
      fifo_rd_data <= '0;
      fifo_empty   <= 1'b1;
    end else begin
      if (fifo_wr_mon && fifo_rd_en) begin
        // dropped
      end else if (fifo_wr_mon) begin
        fifo_q.push_back(wr_data);
      end else if (fifo_rd_en && fifo_q.size() > 0) begin
        fifo_rd_data <= fifo_q.pop_front();
      end
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic logic [EW-1:0] ew(input logic [OUT_W-1:0] d, input logic [PACK-1:0] k,
                                       input logic l);
    return {l, k, d};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  // Output monitor: a word with valid&&ready at the falling edge is taken at the next rising edge.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_word: got %0h expected none", {out_last, out_keep, out_data});
      end else begin
        check("word", 64'({out_last, out_keep, out_data}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #2;
    rstn = 1'b0; flush = 1'b0; fifo_wr_mon = 1'b0; out_ready = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_keep",  64'(out_keep),  64'd0);
    check("rst_last",  64'(out_last),  64'd0);
    check("rst_stats", 64'({stat_words, stat_stalls}), 64'd0);
  endtask

  task automatic push_pix(input logic [W-1:0] v);
    @(posedge clk); #2;
    fifo_wr_mon = 1'b1;
    wr_data     = v;
  endtask

  task automatic end_push();
    @(posedge clk); #2;
    fifo_wr_mon = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk); #2 flush = 1'b1;
    @(posedge clk); #2 flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      total_cnt++;
      $display("FAIL %s_timeout: got %0d words pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(negedge clk);
    check({name, "_idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [CNT_W-1:0] flen;
    logic [3:0]       npix;
    logic [63:0]      pix;   // pixel i in bits [8i+7:8i]
    logic             do_flush;
    logic [1:0]       nexp;
    logic [EW-1:0]    e0;
    logic [EW-1:0]    e1;
  } vec_t;

  function automatic vec_t mkv(input logic [CNT_W-1:0] fl, input logic [3:0] np,
                               input logic [63:0] px, input logic fls, input logic [1:0] ne,
                               input logic [EW-1:0] a, input logic [EW-1:0] b);
    vec_t v;
    v.flen = fl; v.npix = np; v.pix = px; v.do_flush = fls; v.nexp = ne; v.e0 = a; v.e1 = b;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    logic [OUT_W-1:0] snap;
    int n;

    vecs[0] = mkv(0, 4, 64'h44332211, 1'b0, 2'd1, ew(32'h44332211, 4'hF, 1'b0), '0);
    vecs[1] = mkv(6, 6, 64'h060504030201, 1'b0, 2'd2,
                  ew(32'h04030201, 4'hF, 1'b0), ew(32'h00000605, 4'h3, 1'b1));
    vecs[2] = mkv(0, 2, 64'hBBAA, 1'b1, 2'd1, ew(32'h0000BBAA, 4'h3, 1'b0), '0);
    vecs[3] = mkv(3, 3, 64'h090807, 1'b0, 2'd1, ew(32'h00090807, 4'h7, 1'b1), '0);
    vecs[4] = mkv(0, 8, 64'h1716151413121110, 1'b0, 2'd2,
                  ew(32'h13121110, 4'hF, 1'b0), ew(32'h17161514, 4'hF, 1'b0));
    vecs[5] = mkv(1, 1, 64'h5A, 1'b0, 2'd1, ew(32'h0000005A, 4'h1, 1'b1), '0);
    vecs[6] = mkv(2, 4, 64'hC4C3C2C1, 1'b0, 2'd2,
                  ew(32'h0000C2C1, 4'h3, 1'b1), ew(32'h0000C4C3, 4'h3, 1'b1));
    vecs[7] = mkv(0, 0, 64'h0, 1'b1, 2'd0, '0, '0);

    for (int v = 0; v < 8; v++) begin
      do_reset();
      frame_len = vecs[v].flen;
      if (vecs[v].nexp > 0) exp_q.push_back(vecs[v].e0);
      if (vecs[v].nexp > 1) exp_q.push_back(vecs[v].e1);
      for (int i = 0; i < int'(vecs[v].npix); i++) push_pix(vecs[v].pix[i*8 +: 8]);
      end_push();
      if (vecs[v].do_flush) pulse_flush();
      wait_drain($sformatf("vec%0d", v));
    end

    // T3: back-pressure for 10 cycles; word stable, no pops, FIFO grows.
    do_reset();
    frame_len = '0;
    out_ready = 1'b0;
    exp_q.push_back(ew(32'hA4A3A2A1, 4'hF, 1'b0));
    for (int i = 0; i < 4; i++) push_pix(8'hA1 + 8'(i));
    end_push();
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      total_cnt++;
      $display("FAIL t3_valid_timeout: got out_valid=0 expected 1");
    end
    snap = out_data;
    for (int i = 0; i < 10; i++) begin
      check("t3_hold_data", 64'(out_data), 64'(snap));
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_no_pop", 64'(fifo_rd_en), 64'd0);
      if (i == 9) check("t3_fifo_grows", 64'(fifo_q.size()), 64'd3);
      @(posedge clk); #2;
      if (i < 3) begin
        fifo_wr_mon = 1'b1;
        wr_data     = 8'hA5 + 8'(i);
      end else begin
        fifo_wr_mon = 1'b0;
      end
      if (i == 9) out_ready = 1'b1;
      @(negedge clk);
    end
    exp_q.push_back(ew(32'h00A7A6A5, 4'h7, 1'b0));
    pulse_flush();
    wait_drain("t3");
`ifdef DRAIN_STATS_EN
    check("t3_stat_stalls", 64'(stat_stalls), 64'd10);
    check("t3_stat_words",  64'(stat_words),  64'd2);
`else
    check("t3_stat_stalls", 64'(stat_stalls), 64'd0);
    check("t3_stat_words",  64'(stat_words),  64'd0);
`endif

    // T4: write monitor high for 5 cycles blocks pops; pop follows once it drops.
    do_reset();
    exp_q.push_back(ew(32'h34333231, 4'hF, 1'b0));
    exp_q.push_back(ew(32'h00000035, 4'h1, 1'b0));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      fifo_wr_mon = 1'b1;
      wr_data     = 8'h31 + 8'(i);
      @(negedge clk);
      if (i > 0) check("t4_blocked", 64'(fifo_rd_en), 64'd0);
    end
    @(posedge clk); #2 fifo_wr_mon = 1'b0;
    @(negedge clk);
    check("t4_pop_after_mon", 64'(fifo_rd_en), 64'd1);
    pulse_flush();
    wait_drain("t4");

    // T6: reset asserted while a pixel is in flight.
    do_reset();
    push_pix(8'h77);
    end_push();
    n = 0;
    @(negedge clk);
    while (!fifo_rd_en && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      total_cnt++;
      $display("FAIL t6_pop_timeout: got fifo_rd_en=0 expected 1");
    end
    @(posedge clk); #2 rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rd_en", 64'(fifo_rd_en), 64'd0);
    check("t6_valid", 64'(out_valid),  64'd0);
    check("t6_data",  64'(out_data),   64'd0);
    check("t6_keep",  64'(out_keep),   64'd0);
    check("t6_last",  64'(out_last),   64'd0);
    @(posedge clk); #2 rstn = 1'b1;
    exp_q.push_back(ew(32'h04030201, 4'hF, 1'b0));
    for (int i = 0; i < 4; i++) push_pix(8'h01 + 8'(i));
    end_push();
    wait_drain("t6");

    // Randomised unframed burst with random back-pressure.
    do_reset();
    begin
      logic [OUT_W-1:0] w;
      for (int k = 0; k < 3; k++) begin
        w = '0;
        for (int i = 0; i < PACK; i++) w[i*W +: W] = 8'($urandom_range(0, 255));
        exp_q.push_back(ew(w, 4'hF, 1'b0));
        for (int i = 0; i < PACK; i++) push_pix(w[i*W +: W]);
      end
      end_push();
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #2 out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #2 out_ready = 1'b1;
      wait_drain("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
